// File: rtl/parking_pkg.sv
// Shared constants and types for the parking-lot dot-matrix display path.
package parking_pkg;

    localparam int unsigned ROW_COUNT = 8;
    localparam int unsigned SCAN_W    = 3;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned DIGIT_MAX = 8;

    typedef logic [SCAN_W-1:0]  scan_t;
    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic {
        PhaseOff = 1'b0,
        PhaseOn  = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/scan_tick_gen.sv
// Row-rate divider: pulses row_tick once every TICK_DIV cycles while run is high.
module scan_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic row_tick
);

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    assign row_tick = run && (div_q == DivLast);

    always_comb begin
        div_d = div_q;
        if (!run) begin
            div_d = '0;
        end else if (row_tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// Row scan, frame-synchronous digit update and blink control for the 8x8 dot-matrix block.
module dot_matrix_scan_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               power,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic               blink_en,
    output logic [SCAN_W-1:0]  scan_cnt,
    output logic [DIGIT_W-1:0] num,
    output logic               enable,
    output logic               frame_done
);

    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
    localparam scan_t LastRow = scan_t'(ROW_COUNT - 1);

    scan_t             scan_q, scan_d;
    digit_t            num_q, num_d;
    digit_t            pend_q, pend_d;
    logic              ready_q, ready_d;
    logic              enable_q, enable_d;
    logic              frame_done_q, frame_done_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    blink_phase_e      phase_q, phase_d;
    logic              power_q;

    logic row_tick;
    logic frame_end;
    logic accept;
    logic blink_wrap;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (power),
        .row_tick (row_tick)
    );

    assign frame_end  = row_tick && (scan_q == LastRow);
    assign accept     = digit_valid && ready_q;
    assign blink_wrap = (blink_cnt_q == BlinkLast);

    // Scan, blink phase and enable next-state.
    always_comb begin
        scan_d       = scan_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        enable_d     = enable_q;
        frame_done_d = 1'b0;
        if (!power) begin
            scan_d      = '0;
            blink_cnt_d = '0;
            phase_d     = PhaseOn;
            enable_d    = 1'b0;
        end else begin
            if (row_tick) begin
                scan_d = scan_q + 1'b1;
            end
            if (frame_end) begin
                frame_done_d = 1'b1;
                blink_cnt_d  = blink_wrap ? '0 : blink_cnt_q + 1'b1;
                if (!blink_en) begin
                    phase_d = PhaseOn;
                end else if (blink_wrap) begin
                    phase_d = (phase_q == PhaseOn) ? PhaseOff : PhaseOn;
                end
                enable_d = !blink_en || (phase_d == PhaseOn);
            end else if (!power_q) begin
                enable_d = !blink_en || (phase_q == PhaseOn);
            end
        end
    end

    // Pending buffer: loads num only at a frame boundary; accept and load are exclusive
    // because accept requires an empty buffer.
    always_comb begin
        num_d   = num_q;
        pend_d  = pend_q;
        ready_d = ready_q;
        if (frame_end && !ready_q) begin
            num_d   = pend_q;
            ready_d = 1'b1;
        end
        if (accept) begin
            pend_d  = digit_in;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q       <= '0;
            num_q        <= '0;
            pend_q       <= '0;
            ready_q      <= 1'b1;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= PhaseOn;
            power_q      <= 1'b0;
        end else begin
            scan_q       <= scan_d;
            num_q        <= num_d;
            pend_q       <= pend_d;
            ready_q      <= ready_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            power_q      <= power;
        end
    end

    assign scan_cnt    = scan_q;
    assign num         = num_q;
    assign digit_ready = ready_q;
    assign enable      = enable_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Bench for dot_matrix_scan_ctrl against a frame-arithmetic reference model.
module tb_dot_matrix_scan_ctrl;

    localparam int unsigned TD    = 4;
    localparam int unsigned BF    = 2;
    localparam int unsigned FRAME = 8 * TD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power = 1'b0;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0;
    logic       digit_ready;
    logic       blink_en = 1'b0;
    logic [2:0] scan_cnt;
    logic [3:0] num;
    logic       enable;
    logic       frame_done;

    int total = 0;
    int bad = 0;

    // Reference model: m_k counts powered cycles since power-on.
    int         m_k = 0;
    bit         m_prev_pw = 0;
    bit         m_phase = 1;
    logic [3:0] m_num = '0;
    bit         m_en = 0;
    bit         m_fd = 0;
    logic [2:0] m_scan = '0;
    bit         m_acc = 0;
    logic [3:0] m_q[$];

    dot_matrix_scan_ctrl #(
        .TICK_DIV     (TD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power       (power),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .blink_en    (blink_en),
        .scan_cnt    (scan_cnt),
        .num         (num),
        .enable      (enable),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic bit m_rdy();
        return m_q.size() == 0;
    endfunction

    task automatic tick();
        bit bnd;
        @(posedge clk);
        m_acc = digit_valid && m_rdy();
        if (!rst_n) begin
            m_q.delete();
            m_k = 0; m_prev_pw = 0; m_phase = 1; m_num = '0;
            m_en = 0; m_fd = 0; m_scan = '0; m_acc = 0;
        end else begin
            if (!power) begin
                m_k = 0; m_prev_pw = 0; m_phase = 1; m_en = 0; m_fd = 0; m_scan = '0;
            end else begin
                bnd  = (m_k % FRAME) == FRAME - 1;
                m_fd = bnd;
                m_k++;
                m_scan = 3'((m_k / TD) % 8);
                if (bnd) begin
                    if (m_q.size() > 0) m_num = m_q.pop_front();
                    if (!blink_en) m_phase = 1;
                    else if (((m_k / FRAME) % BF) == 0) m_phase = !m_phase;
                    m_en = !blink_en || m_phase;
                end else if (!m_prev_pw) begin
                    m_en = !blink_en || m_phase;
                end
                m_prev_pw = 1;
            end
            if (m_acc) m_q.push_back(digit_in);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; power = 1'b1; digit_valid = 1'b0; blink_en = 1'b0;
        tick(); tick();
        total++;
        if ({scan_cnt, num, enable, frame_done, digit_ready} !== {3'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset: scan=%0d num=%0d en=%0b fd=%0b rdy=%0b required 0 0 0 0 1",
                     scan_cnt, num, enable, frame_done, digit_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int dut_fd = 0, mdl_fd = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            dut_fd += int'(frame_done);
            mdl_fd += int'(m_fd);
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL scan c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
        total++;
        if (dut_fd !== mdl_fd) begin
            bad++;
            $display("FAIL scan_fd_count: got %0d required %0d", dut_fd, mdl_fd);
        end
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 64 && m_scan != 3'd3; i++) tick();
        digit_in = 4'd5; digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        total++;
        if (digit_ready !== 1'b0) begin
            bad++;
            $display("FAIL hs_ready_drop: got %0b required 0", digit_ready);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL hs c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
        total++;
        if (num !== 4'd5) begin
            bad++;
            $display("FAIL hs_num: got %0d required 5", num);
        end
    endtask

    task automatic test_boundary_accept();
        for (int i = 0; i < 64 && (m_k % FRAME) != FRAME - 1; i++) tick();
        digit_in = 4'd2; digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        total++;
        if (num !== 4'd5) begin
            bad++;
            $display("FAIL bnd_hold: got num %0d required 5", num);
        end
        for (int i = 0; i < 33; i++) begin
            tick();
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL bnd c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
        total++;
        if (num !== 4'd2) begin
            bad++;
            $display("FAIL bnd_num: got %0d required 2", num);
        end
    endtask

    task automatic test_back_to_back();
        bit seen3 = 0;
        digit_in = 4'd3; digit_valid = 1'b1;
        tick();
        digit_in = 4'd7;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (m_acc && digit_in == 4'd7) digit_valid = 1'b0;
            if (num == 4'd3) seen3 = 1;
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL b2b c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
        digit_valid = 1'b0;
        total++;
        if (!seen3 || num !== 4'd7) begin
            bad++;
            $display("FAIL b2b_seq: seen3=%0b num=%0d required seen3=1 num=7", seen3, num);
        end
    endtask

    task automatic test_blink();
        logic prev_en;
        blink_en = 1'b1;
        prev_en = enable;
        for (int i = 0; i < 6 * FRAME; i++) begin
            tick();
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL blink c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
            total++;
            if (enable !== prev_en && frame_done !== 1'b1) begin
                bad++;
                $display("FAIL blink_edge c%0d: enable moved to %0b without frame_done", i, enable);
            end
            prev_en = enable;
        end
        for (int i = 0; i < 64 && (m_k % FRAME) != 10; i++) tick();
        blink_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL unblink c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL unblink_en: got %0b required 1", enable);
        end
    endtask

    task automatic test_power();
        digit_in = 4'd4; digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        for (int i = 0; i < 70; i++) tick();
        for (int i = 0; i < 64 && !((m_k % TD) == 1 && m_scan != 0); i++) tick();
        power = 1'b0;
        tick();
        total++;
        if ({enable, scan_cnt, num} !== {1'b0, 3'd0, 4'd4}) begin
            bad++;
            $display("FAIL pwr_off: en=%0b scan=%0d num=%0d required 0 0 4", enable, scan_cnt, num);
        end
        digit_in = 4'd6; digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        total++;
        if (digit_ready !== 1'b0 || num !== 4'd4) begin
            bad++;
            $display("FAIL pwr_off_accept: rdy=%0b num=%0d required 0 4", digit_ready, num);
        end
        tick();
        power = 1'b1;
        tick();
        total++;
        if ({enable, scan_cnt} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL pwr_on: en=%0b scan=%0d required 1 0", enable, scan_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL pwr c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
        digit_in = 4'd1; digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({num, digit_ready, enable} !== {4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: num=%0d rdy=%0b en=%0b required 0 1 0", num, digit_ready, enable);
        end
        for (int i = 0; i < 40; i++) tick();
        total++;
        if (num !== 4'd0) begin
            bad++;
            $display("FAIL reset_discard: num=%0d required 0", num);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) power = !power;
            if ($urandom_range(0, 99) == 0) blink_en = !blink_en;
            digit_valid = ($urandom_range(0, 9) < 3);
            digit_in    = 4'($urandom_range(0, 15));
            tick();
            total++;
            if ({scan_cnt, num, enable, frame_done, digit_ready} !==
                {m_scan, m_num, m_en, m_fd, m_rdy()}) begin
                bad++;
                $display("FAIL rand c%0d: got s%0d n%0d e%0b f%0b r%0b want s%0d n%0d e%0b f%0b r%0b",
                         i, scan_cnt, num, enable, frame_done, digit_ready,
                         m_scan, m_num, m_en, m_fd, m_rdy());
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_scan();
        test_handshake();
        test_boundary_accept();
        test_back_to_back();
        test_blink();
        test_power();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
